sid_mix_seq: RTL and testbench



---
 rtl/sid_pkg.sv | 23 ++
 rtl/sid_clip.sv | 21 ++
 rtl/sid_mix_seq.sv | 166 ++++++++++++++++
 tb/tb_sid_mix_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared definitions for the sequential SID mixer.
//   state_t  : mixer pass sequencer states
//   REG_*    : register offsets from BASE_ADDR
//   MODE_*   : bit positions inside the filter-output select field
package sid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      FILT,
      WAIT_FILT,
      POST,
      VOL
   } state_t;

   localparam int REG_FILT = 0;   // routing register
   localparam int REG_MODE = 1;   // mode / volume register

   localparam int MODE_LP = 0;
   localparam int MODE_BP = 1;
   localparam int MODE_HP = 2;

endpackage

// File: rtl/sid_clip.sv
// Combinational saturating narrower: signed IW-bit value to signed OW-bit.
//   d : signed input, IW bits (IW > OW)
//   q : d clamped to [-2^(OW-1), 2^(OW-1)-1]
module sid_clip #(
   parameter int IW = 19,
   parameter int OW = 16
) (
   input  logic signed [IW-1:0] d,
   output logic signed [OW-1:0] q
);

   // Value fits when every bit above the output sign bit matches the sign.
   logic fits;
   assign fits = (d[IW-1:OW-1] == {(IW-OW+1){d[IW-1]}});

   always_comb begin
      q = d[OW-1:0];
      if (!fits) q = d[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
   end

endmodule

// File: rtl/sid_mix_seq.sv
// Time-multiplexed SID voice mixer / output stage.
// Each audio tick runs one pass: a single shared multiplier scales voice n by
// envelope n (one voice per cycle) into a filter or bypass accumulator, the
// clipped filter accumulator is handed to an external filter, the selected
// filter outputs are mixed with the bypass sum, clipped and volume-scaled.
//   clk, iRstN           : clock, async active-low reset
//   clkEn                : audio tick, starts a pass when idle
//   iWE/iAddr/iDataW     : register writes (routing at BASE_ADDR, mode/vol at +1)
//   iVoice/iEnv          : packed voice samples / envelopes
//   oFilt/oFiltValid     : filter input and its 1-cycle start strobe
//   iFiltLP/BP/HP/Valid  : filter results
//   oOut/oValid          : audio sample and new-sample strobe
//   oBusy/oOverrun       : pass in progress / sticky tick-while-busy flag
module sid_mix_seq
   import sid_pkg::*;
#(
   parameter int         VOICES    = 3,
   parameter int         VW        = 12,
   parameter int         EW        = 8,
   parameter int         OW        = 16,
   parameter int         HEADROOM  = 3,
   parameter logic [4:0] BASE_ADDR = 5'h17
) (
   input  logic                   clk,
   input  logic                   iRstN,
   input  logic                   clkEn,
   input  logic                   iWE,
   input  logic [4:0]             iAddr,
   input  logic [7:0]             iDataW,
   input  logic [VOICES*VW-1:0]   iVoice,
   input  logic [VOICES*EW-1:0]   iEnv,
   output logic signed [OW-1:0]   oFilt,
   output logic                   oFiltValid,
   input  logic signed [OW-1:0]   iFiltLP,
   input  logic signed [OW-1:0]   iFiltBP,
   input  logic signed [OW-1:0]   iFiltHP,
   input  logic                   iFiltValid,
   output logic signed [OW-1:0]   oOut,
   output logic                   oValid,
   output logic                   oBusy,
   output logic                   oOverrun
);

   localparam int IXW   = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int ACCW  = OW + $clog2(VOICES) + 1;
   localparam int PW    = VW + EW + 1;
   localparam int SW    = ACCW + 2;
   localparam int PRESH = VW + EW - OW;

   state_t                 state, nstate;
   logic [IXW-1:0]         idx;
   logic [VOICES-1:0]      routing, rtS;
   logic [2:0]             mode, modeS;
   logic [3:0]             volume, volS;
   logic signed [ACCW-1:0] filtAcc, bypAcc, aExt, filtCand;
   logic signed [OW-1:0]   lpR, bpR, hpR, filtClip, mixClip, volOut;
   logic [VW-1:0]          vSel;
   logic [EW-1:0]          eSel;
   logic signed [VW-1:0]   s;
   logic signed [PW-1:0]   p, pSh;
   logic signed [SW-1:0]   sum;
   logic signed [OW+4:0]   prod;
   logic                   lastStep, routeBit;
   logic                   unused_ok;

   assign unused_ok = &{1'b0, iDataW[7]};

   // ---- shared MAC datapath ----
   assign vSel     = iVoice[idx*VW +: VW];
   assign eSel     = iEnv[idx*EW +: EW];
   assign s        = $signed({~vSel[VW-1], vSel[VW-2:0]});   // offset-binary -> two's complement
   assign p        = s * $signed({1'b0, eSel});
   assign pSh      = (p >>> PRESH) >>> HEADROOM;
   assign aExt     = ACCW'(pSh);                              // post-shift value fits in OW+1 bits
   assign routeBit = rtS[idx];
   assign lastStep = (idx == IXW'(VOICES-1));
   // Filter accumulator as it will be after this step; lets oFilt load on the last MAC edge.
   assign filtCand = routeBit ? (filtAcc + aExt) : filtAcc;

   sid_clip #(.IW(ACCW), .OW(OW)) u_clip_filt (.d(filtCand), .q(filtClip));

   // ---- post mix and volume ----
   assign sum = SW'(bypAcc)
              + (modeS[MODE_LP] ? SW'(lpR) : SW'(0))
              + (modeS[MODE_BP] ? SW'(bpR) : SW'(0))
              + (modeS[MODE_HP] ? SW'(hpR) : SW'(0));

   sid_clip #(.IW(SW), .OW(OW)) u_clip_post (.d(sum), .q(mixClip));

   assign prod   = mixClip * $signed({1'b0, volS});
   assign volOut = OW'(prod >>> 4);

   // ---- sequencer ----
   always_comb begin
      nstate     = state;
      oFiltValid = 1'b0;
      oValid     = 1'b0;
      oBusy      = (state != IDLE);
      case (state)
         IDLE:      if (clkEn) nstate = MAC;
         MAC:       if (lastStep) nstate = FILT;
         FILT:      begin oFiltValid = 1'b1; nstate = WAIT_FILT; end
         WAIT_FILT: if (iFiltValid) nstate = POST;
         POST:      nstate = VOL;
         VOL:       begin oValid = 1'b1; nstate = IDLE; end
         default:   nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         state    <= IDLE;
         idx      <= '0;
         routing  <= '0;
         mode     <= '0;
         volume   <= 4'hF;
         rtS      <= '0;
         modeS    <= '0;
         volS     <= 4'hF;
         filtAcc  <= '0;
         bypAcc   <= '0;
         lpR      <= '0;
         bpR      <= '0;
         hpR      <= '0;
         oFilt    <= '0;
         oOut     <= '0;
         oOverrun <= 1'b0;
      end else begin
         state <= nstate;

         if (iWE && iAddr == BASE_ADDR + 5'(REG_FILT)) routing <= iDataW[VOICES-1:0];
         if (iWE && iAddr == BASE_ADDR + 5'(REG_MODE)) begin
            mode   <= iDataW[6:4];
            volume <= iDataW[3:0];
         end

         if (clkEn && state != IDLE) oOverrun <= 1'b1;

         case (state)
            IDLE: if (clkEn) begin
               // Snapshot control regs so mid-pass writes only affect the next pass.
               rtS     <= routing;
               modeS   <= mode;
               volS    <= volume;
               filtAcc <= '0;
               bypAcc  <= '0;
               idx     <= '0;
            end
            MAC: begin
               if (routeBit) filtAcc <= filtAcc + aExt;
               else          bypAcc  <= bypAcc + aExt;
               idx <= idx + 1'b1;
               if (lastStep) oFilt <= filtClip;
            end
            WAIT_FILT: if (iFiltValid) begin
               lpR <= iFiltLP;
               bpR <= iFiltBP;
               hpR <= iFiltHP;
            end
            POST: oOut <= volOut;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sid_mix_seq.sv
module tb_sid_mix_seq;

   logic               clk = 1'b0;
   logic               iRstN, clkEn, iWE, iFiltValid;
   logic [4:0]         iAddr;
   logic [7:0]         iDataW;
   logic [35:0]        iVoice;
   logic [23:0]        iEnv;
   logic signed [15:0] iFiltLP, iFiltBP, iFiltHP;
   logic signed [15:0] oFilt, oOut, oFilt0, oOut0;
   logic               oFiltValid, oValid, oBusy, oOverrun;
   logic               oFiltValid0, oValid0, oBusy0, oOverrun0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sid_mix_seq dut (
      .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iWE(iWE), .iAddr(iAddr), .iDataW(iDataW),
      .iVoice(iVoice), .iEnv(iEnv), .oFilt(oFilt), .oFiltValid(oFiltValid),
      .iFiltLP(iFiltLP), .iFiltBP(iFiltBP), .iFiltHP(iFiltHP), .iFiltValid(iFiltValid),
      .oOut(oOut), .oValid(oValid), .oBusy(oBusy), .oOverrun(oOverrun)
   );

   // Same stimulus, no headroom shift: exercises post-mix clipping.
   sid_mix_seq #(.HEADROOM(0)) dut0 (
      .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iWE(iWE), .iAddr(iAddr), .iDataW(iDataW),
      .iVoice(iVoice), .iEnv(iEnv), .oFilt(oFilt0), .oFiltValid(oFiltValid0),
      .iFiltLP(iFiltLP), .iFiltBP(iFiltBP), .iFiltHP(iFiltHP), .iFiltValid(iFiltValid),
      .oOut(oOut0), .oValid(oValid0), .oBusy(oBusy0), .oOverrun(oOverrun0)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      iWE = 1'b1; iAddr = a; iDataW = d;
      @(negedge clk);
      iWE = 1'b0;
   endtask

   // One mix pass. Cycle 0 is the clkEn cycle; outputs sampled at each negedge.
   // The filter model answers 3 cycles after oFiltValid, LP optionally echoing oFilt.
   task automatic run_pass(input bit echo, input int ovr, input int wcyc, input logic [7:0] wdata,
                           output int fvc, output int vc, output int filt, output int out,
                           output int out0, output int busyV);
      int  n;
      bit  done;
      fvc = -1; vc = -1; filt = 0; out = 0; out0 = 0; busyV = 0; done = 0;
      clkEn = 1'b1; n = 0;
      while (!done && n < 40) begin
         @(negedge clk); n++;
         if (oFiltValid && fvc < 0) begin fvc = n; filt = oFilt; end
         if (oValid) begin vc = n; out = oOut; out0 = oOut0; busyV = oBusy; done = 1; end
         clkEn      = (n == ovr);
         iWE        = (n == wcyc);
         iAddr      = 5'h18;
         iDataW     = wdata;
         iFiltValid = (fvc >= 0 && n == fvc + 3);
         iFiltLP    = (iFiltValid && echo) ? oFilt : 16'sd0;
      end
      clkEn = 1'b0; iWE = 1'b0; iFiltValid = 1'b0; iFiltLP = '0;
      @(negedge clk);
   endtask

   initial begin
      int fvc, vc, filt, out, out0, busyV, seen;
      iRstN = 1'b0; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iDataW = '0;
      iFiltValid = 1'b0; iFiltLP = '0; iFiltBP = '0; iFiltHP = '0;
      iVoice = {12'h800, 12'h800, 12'hFFF};
      iEnv   = {8'd255, 8'd255, 8'd255};
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_oOut", oOut, 0);
      chk("rst_oFilt", oFilt, 0);
      chk("rst_oValid", oValid, 0);
      chk("rst_oFiltValid", oFiltValid, 0);
      chk("rst_oBusy", oBusy, 0);
      chk("rst_oOverrun", oOverrun, 0);
      iRstN = 1'b1;
      @(negedge clk);

      // 1: bypass only, vol 15 from reset
      run_pass(0, -1, -1, 8'h00, fvc, vc, filt, out, out0, busyV);
      chk("t1_fv_cycle", fvc, 4);
      chk("t1_oFilt", filt, 0);
      chk("t1_valid_cycle", vc, 9);
      chk("t1_oOut", out, 3823);
      chk("t1_busy_at_valid", busyV, 1);
      chk("t1_busy_after", oBusy, 0);
      chk("t1_overrun", oOverrun, 0);

      // 2: most negative voice, vol 8
      iVoice = {12'h800, 12'h800, 12'h000};
      wr(5'h18, 8'h08);
      run_pass(0, -1, -1, 8'h08, fvc, vc, filt, out, out0, busyV);
      chk("t2_oOut", out, -2040);

      // 3: all voices full scale; HEADROOM=0 copy clips
      iVoice = {12'hFFF, 12'hFFF, 12'hFFF};
      wr(5'h18, 8'h0F);
      run_pass(0, -1, -1, 8'h0F, fvc, vc, filt, out, out0, busyV);
      chk("t3_clip_oOut", out0, 30719);
      chk("t3_hr3_oOut", out, 11469);

      // 4: voice 0 through filter, LP selected and echoed
      iVoice = {12'h800, 12'h800, 12'hFFF};
      wr(5'h17, 8'h01);
      wr(5'h18, 8'h1F);
      run_pass(1, -1, -1, 8'h1F, fvc, vc, filt, out, out0, busyV);
      chk("t4_oFilt", filt, 4078);
      chk("t4_oOut", out, 3823);
      wr(5'h18, 8'h0F);
      run_pass(1, -1, -1, 8'h0F, fvc, vc, filt, out, out0, busyV);
      chk("t4_mode0_oOut", out, 0);

      // 5: tick during WAIT_FILT, volume 0 written mid-pass
      wr(5'h17, 8'h00);
      run_pass(0, 6, 2, 8'h00, fvc, vc, filt, out, out0, busyV);
      chk("t5_valid_cycle", vc, 9);
      chk("t5_oOut", out, 3823);
      chk("t5_overrun", oOverrun, 1);
      chk("t5_no_restart", oBusy, 0);
      run_pass(0, -1, -1, 8'h00, fvc, vc, filt, out, out0, busyV);
      chk("t5_next_oOut", out, 0);
      chk("t5_overrun_sticky", oOverrun, 1);

      // 6: reset in the middle of MAC
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      @(negedge clk);
      chk("t6_busy_before", oBusy, 1);
      iRstN = 1'b0;
      #1;
      chk("t6_oOut", oOut, 0);
      chk("t6_oFilt", oFilt, 0);
      chk("t6_oBusy", oBusy, 0);
      chk("t6_oValid", oValid, 0);
      chk("t6_oOverrun", oOverrun, 0);
      @(negedge clk);
      iRstN = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (oValid || oBusy || oFiltValid) seen++;
      end
      chk("t6_quiet", seen, 0);
      run_pass(0, -1, -1, 8'h00, fvc, vc, filt, out, out0, busyV);
      chk("t6_valid_cycle", vc, 9);
      chk("t6_oOut_vol_reset", out, 3823);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
